// File: rtl/instruction_decode_stage.sv
// Registered IF/ID decode stage: 2-entry FIFO of fetched words, with fields and
// the raw (unshifted, zero-extended) immediate decoded at push time.
module instruction_decode_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [31:0] out_raw_imm,
  output logic        out_illegal
);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_ITYPE  = 7'b0010011,
    OP_RTYPE  = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] raw_imm;
    logic        illegal;
  } entry_t;

  entry_t      r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic [31:0] w_imm;
  logic        w_illegal;
  logic        w_push;
  logic        w_pop;
  entry_t      w_head;

  always_comb begin
    w_imm     = '0;
    w_illegal = 1'b0;
    if (in_instruction[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (in_instruction[6:0])
        OP_JALR, OP_LOAD, OP_ITYPE, OP_FENCE, OP_SYSTEM:
          w_imm = {20'b0, in_instruction[31:20]};
        OP_STORE:
          w_imm = {20'b0, in_instruction[31:25], in_instruction[11:7]};
        OP_BRANCH:
          w_imm = {20'b0, in_instruction[31], in_instruction[7],
                   in_instruction[30:25], in_instruction[11:8]};
        OP_LUI, OP_AUIPC:
          w_imm = {12'b0, in_instruction[31:12]};
        OP_JAL:
          w_imm = {12'b0, in_instruction[31], in_instruction[19:12],
                   in_instruction[20], in_instruction[30:21]};
        OP_RTYPE:
          w_imm = '0;
        default:
          w_illegal = 1'b1;
      endcase
    end
  end

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  // flush suppresses both handshakes so the pointers and count stay coherent
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{pc: in_pc, inst: in_instruction,
                              raw_imm: w_imm, illegal: w_illegal};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign out_pc      = w_head.pc;
  assign out_opcode  = w_head.inst[6:0];
  assign out_rd      = w_head.inst[11:7];
  assign out_funct3  = w_head.inst[14:12];
  assign out_rs1     = w_head.inst[19:15];
  assign out_rs2     = w_head.inst[24:20];
  assign out_funct7  = w_head.inst[31:25];
  assign out_raw_imm = w_head.raw_imm;
  assign out_illegal = w_head.illegal;

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Registered IF/ID decode stage for the RV32I core. Accepts fetched instruction words with their PC over a valid/ready handshake, buffers up to two of them, and splits each one into opcode, register indices, funct fields and the format-specific raw immediate field. It sits between instruction fetch and the immediate generator and register file: `out_opcode` and `out_raw_imm` drive the immediate generator's `opcode` and `raw_imm` inputs directly.

## Interface
- No parameters. Buffer depth is fixed at 2 entries.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `flush` input 1: discard all buffered entries and any push in the same cycle.
- `in_valid` input 1: fetch presents a word.
- `in_ready` output 1: stage can accept a word.
- `in_instruction` input 32: instruction word.
- `in_pc` input 32: PC of the word.
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: downstream consumes the head entry.
- `out_pc` output 32: PC of the head entry.
- `out_opcode` output 7: inst[6:0].
- `out_rd`, `out_rs1`, `out_rs2` output 5 each: inst[11:7], inst[19:15], inst[24:20].
- `out_funct3` output 3: inst[14:12].
- `out_funct7` output 7: inst[31:25].
- `out_raw_imm` output 32: zero-extended immediate field, unshifted.
- `out_illegal` output 1: unknown opcode, or inst[1:0] != 2'b11.

## Operation
- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`. The buffer is a 2-entry FIFO with entry count 0..2.
- Fields are decoded at push time and stored with the entry. The outputs come only from the head entry's registers, with no combinational path from `in_*`.
- `out_raw_imm` by opcode:
  - I-type (JALR, LOAD, ITYPE, FENCE, ENVIRONMENT): {20'b0, inst[31:20]}.
  - S-type (STORE): {20'b0, inst[31:25], inst[11:7]}.
  - B-type (BRANCH): {20'b0, inst[31], inst[7], inst[30:25], inst[11:8]}.
  - U-type (LUI, AUIPC): {12'b0, inst[31:12]}.
  - J-type (JAL): {12'b0, inst[31], inst[19:12], inst[20], inst[30:21]}.
  - RTYPE or illegal: 0.
- Illegal entry: `out_illegal`=1 and `out_raw_imm`=0. All other fields are still passed through. The entry flows normally.
- `in_ready` = (count < 2). It is a function of state only and never depends on `out_ready` in the same cycle.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together (count 1): unchanged. The new entry becomes head on the next edge.
- `flush`: count becomes 0 on the next edge. A push and a pop in the flush cycle are both discarded. `flush` has priority over everything else.

## Timing
- Reset (async assert, sync release): count=0, `out_valid`=0, `in_ready`=1, and all data outputs are 0.
- Latency: a word pushed into the empty stage at edge N gives `out_valid`=1 after edge N with the decoded fields.
- Throughput: 1 word/cycle while `out_ready`=1.
- Full (count 2): `in_ready`=0 and `in_valid` is ignored. One pop returns `in_ready` to 1 after that edge.
- Empty: `out_valid`=0 and `out_ready` is ignored. Data outputs hold their last value and are don't-care.
- The head entry's outputs stay stable while `out_valid && !out_ready`.
- `reset_n` asserted mid-transfer: in-flight entries are lost immediately, with no partial-state recovery.

## Test plan
- Decode all formats, pushed back-to-back with `out_ready`=1. Each appears one cycle after push:
  - 0xFFF10093 -> opcode 0x13, rd 1, rs1 2, funct3 0, raw_imm 0x00000FFF.
  - 0x00512423 -> opcode 0x23, rs1 2, rs2 5, funct3 2, raw_imm 0x008.
  - 0xFE000EE3 -> opcode 0x63, raw_imm 0x00000FFE.
  - 0xDEADB0B7 -> opcode 0x37, rd 1, raw_imm 0x000DEADB.
  - 0x008000EF -> opcode 0x6F, rd 1, raw_imm 0x00000004.
- R-type 0x002081B3 -> raw_imm 0, `out_illegal`=0. Word 0x00000000 -> `out_illegal`=1, raw_imm 0.
- Backpressure: hold `out_ready`=0 and push PCs 0x100 and 0x104.
  - `in_ready` falls after the second push, and a third word offered is not accepted.
  - Raise `out_ready`: PCs emerge in the order 0x100, 0x104, and the third word is then accepted.
- Count 1 with simultaneous push and pop for 8 cycles -> `out_valid` stays 1 and PCs stay in order with no drops or duplicates.
- With count 2, assert `flush` together with `in_valid` -> the next cycle has `out_valid`=0, `in_ready`=1, and the flushed-cycle word never appears.
- Assert `reset_n` low mid-stream, between clock edges -> `out_valid`=0 and all outputs 0 immediately. After release, the first push is decoded normally.
